poly_decim: RTL and testbench
=============================

// Module: poly_decim
// PURPOSE
//  Polyphase decimating FIR: the receive-side counterpart of the AWG interpolator.
//  Accepts 16-bit signed samples on a cke strobe and low-pass filters them with a runtime tap set.
//  Emits one output per `rate` inputs, with a cke_out strobe.
//  A single time-multiplexed MAC runs over a snapshot of the delay line.
//  Sits between the ADC/capture path and the downstream sample-rate-reduced logic.
// PARAMETERS
//  rate     4                   decimation factor (>=2)
//  tap_len  8                   FIR length (>=2); taps Q1.15 signed
//  acc_w    32+$clog2(tap_len)  accumulator width, no internal overflow
// PORTS
//  clk      in   1          system clock
//  rst      in   1          synchronous reset, active-low (0 = reset)
//  cke      in   1          input sample strobe, one cycle per sample
//  din      in   16         signed input sample, valid when cke=1
//  tap      in   tap_len*16 packed signed Q1.15 taps, tap[0] applies to newest sample; static while busy
//  dout     out  16         signed output sample, held between strobes
//  cke_out  out  1          one-cycle pulse, dout updated
//  busy     out  1          MAC in progress
//  ovf      out  1          sticky overrun flag, cleared only by reset
// BEHAVIOUR
//  Reset (rst=0 at edge):
//   - sr, snap, acc, dout cleared to 0; cke_out=0, busy=0, ovf=0.
//   - Phase counter ph=0; state=IDLE.
//   - Reset mid-MAC aborts the calculation; no cke_out is issued.
//  Delay line sr[tap_len-1:0] (sr[0] newest):
//   - On cke, shift din into sr[0]; this is independent of FSM state.
//  Phase counter:
//   - On cke, ph increments modulo rate.
//   - cke with ph==rate-1 is a start request; ph wraps to 0.
//  FSM IDLE/MAC/OUT:
//   - IDLE + start: snap <= shifted sr (includes current din), acc<=0, k<=0 -> MAC.
//   - MAC: acc += snap[k]*tap[k] (signed 16x16 -> 32, sign-extended to acc_w).
//     k increments; after k==tap_len-1 is accumulated -> OUT.
//   - OUT: dout <= sat16(acc >>> 15) (floor, saturate to +32767/-32768); cke_out<=1 for one cycle -> IDLE.
//  Latency and throughput:
//   - Start cke in cycle 0 -> busy high in cycles 1..tap_len+1.
//   - cke_out high and new dout in cycle tap_len+2.
//   - Starts must be >= tap_len+2 cycles apart.
//  Overrun:
//   - A start request while state!=IDLE (MAC or OUT) is dropped and sets ovf.
//   - The running MAC continues unaffected; sr and ph still advance.
//  Other rules:
//   - cke_out is never asserted outside OUT.
//   - dout is unchanged except in OUT.
//   - cke asserted during reset is ignored.
// TESTING
//  1 Reset: rst=0 for 3 cycles with cke toggling -> dout=0, cke_out=0, busy=0, ovf=0, no shift.
//  2 Impulse: tap[k]=(k+1)*1024, rate=4, din=32767 on first cke then zeros, cke every 12 cycles
//    -> dout sequence 4095, 8191, 0, 0; cke_out at cycle tap_len+2 after each 4th cke.
//  3 DC gain: all taps 0x1000, din=8000 constant -> after 2nd output dout=8000 steady.
//  4 Saturation: all taps 0x7FFF, din=32767 -> dout=32767; din=-32768 -> dout=-32768.
//  5 Overrun: cke every cycle -> starts 4 cycles apart, ovf=1, cke_out only for accepted starts.
//    ovf stays 1 after cke stops, until reset.
//  6 Reset mid-MAC: rst=0 at cycle 3 of MAC -> busy=0 next cycle, no cke_out, dout=0.
//    Next start after release yields a correct result.

Source files
------------

// File: rtl/poly_decim_if.sv
// Sample-stream bundle for poly_decim: input strobe/sample/taps and filtered output.
interface poly_decim_if #(
  parameter int unsigned tap_len = 8
);
  logic                      cke;
  logic signed [15:0]        din;
  logic [tap_len*16-1:0]     tap;
  logic signed [15:0]        dout;
  logic                      cke_out;
  logic                      busy;
  logic                      ovf;

  modport master (output cke, din, tap, input  dout, cke_out, busy, ovf);
  modport slave  (input  cke, din, tap, output dout, cke_out, busy, ovf);
endinterface

// File: rtl/poly_decim.sv
// Polyphase decimating FIR: one output per `rate` input strobes, computed by a
// single time-multiplexed MAC over a snapshot of the delay line.
module poly_decim #(
  parameter int unsigned rate    = 4,
  parameter int unsigned tap_len = 8,
  parameter int unsigned acc_w   = 32 + $clog2(tap_len)
) (
  input  logic         clk,
  input  logic         rst,
  poly_decim_if.slave  bus
);
  localparam int unsigned ph_w = (rate > 1) ? $clog2(rate) : 1;
  localparam int unsigned k_w  = (tap_len > 1) ? $clog2(tap_len) : 1;
  localparam logic signed [acc_w-1:0] max16 = acc_w'(32767);
  localparam logic signed [acc_w-1:0] min16 = -acc_w'(32768);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                   state, state_nx;
  logic [ph_w-1:0]          ph;
  logic [k_w-1:0]           k;
  logic signed [15:0]       sr   [tap_len];
  logic signed [15:0]       snap [tap_len];
  logic signed [acc_w-1:0]  acc;
  logic signed [15:0]       dout;
  logic                     cke_out;
  logic                     ovf;

  logic                     start;
  logic signed [15:0]       tap_k;
  logic signed [31:0]       prod;
  logic signed [acc_w-1:0]  shr;
  logic signed [15:0]       sat;

  assign start = bus.cke && (ph == ph_w'(rate - 1));
  assign tap_k = signed'(bus.tap[32'(k)*16 +: 16]);
  assign prod  = snap[k] * tap_k;
  assign shr   = acc >>> 15;
  assign sat   = (shr > max16) ? 16'sh7FFF :
                 (shr < min16) ? 16'sh8000 : shr[15:0];

  assign bus.dout    = dout;
  assign bus.cke_out = cke_out;
  assign bus.busy    = (state != IDLE);
  assign bus.ovf     = ovf;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = MAC;
      MAC:     if (k == k_w'(tap_len - 1)) state_nx = OUT;
      OUT:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < tap_len; i++) begin
        sr[i]   <= '0;
        snap[i] <= '0;
      end
      acc     <= '0;
      k       <= '0;
      ph      <= '0;
      dout    <= '0;
      cke_out <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      cke_out <= 1'b0;
      if (bus.cke) begin
        sr[0] <= bus.din;
        for (int unsigned i = 1; i < tap_len; i++) sr[i] <= sr[i-1];
        ph <= (ph == ph_w'(rate - 1)) ? '0 : ph + ph_w'(1);
      end
      if (start && state != IDLE) ovf <= 1'b1;
      case (state)
        IDLE: if (start) begin
          // Snapshot takes the post-shift view so the current sample is included.
          snap[0] <= bus.din;
          for (int unsigned i = 1; i < tap_len; i++) snap[i] <= sr[i-1];
          acc <= '0;
          k   <= '0;
        end
        MAC: begin
          acc <= acc + {{(acc_w-32){prod[31]}}, prod};
          k   <= k + k_w'(1);
        end
        OUT: begin
          dout    <= sat;
          cke_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_poly_decim.sv
// Directed bench for poly_decim (rate=4, tap_len=8) with hand-computed outputs.
module tb_poly_decim;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   pulses = 0;

  always #5 clk = ~clk;

  poly_decim_if #(.tap_len(8)) bus();

  poly_decim #(.rate(4), .tap_len(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always @(negedge clk) if (bus.cke_out === 1'b1) pulses++;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  task automatic set_taps(input int mode);
    for (int k = 0; k < 8; k++) begin
      case (mode)
        0:       bus.tap[k*16 +: 16] = 16'((k + 1) * 1024);
        1:       bus.tap[k*16 +: 16] = 16'h1000;
        default: bus.tap[k*16 +: 16] = 16'h7FFF;
      endcase
    end
  endtask

  task automatic feed(input int v);
    bus.din = 16'(v);
    bus.cke = 1'b1;
    tick();
    bus.cke = 1'b0;
    bus.din = '0;
  endtask

  // Start sample goes in cycle 0; expects busy in 1, cke_out/new dout in 10.
  task automatic feed_start(input int v, input int exp, input string tag);
    int n;
    int p0;
    p0 = pulses;
    feed(v);
    check({tag, ".busy"}, bus.busy, 1);
    n = 1;
    while (bus.cke_out !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check({tag, ".lat"}, n, 10);
    check({tag, ".dout"}, bus.dout, exp);
    check({tag, ".idle"}, bus.busy, 0);
    tick();
    check({tag, ".pulse"}, bus.cke_out, 0);
    check({tag, ".npulse"}, pulses - p0, 1);
  endtask

  task automatic group(input int v, input int exp, input string tag);
    repeat (3) begin
      feed(v);
      idle(11);
    end
    feed_start(v, exp, tag);
    idle(1);
  endtask

  initial begin
    int p0;
    rst = 1'b0;
    bus.cke = 1'b0;
    bus.din = '0;
    bus.tap = '0;

    // Reset with cke toggling
    repeat (3) begin
      bus.cke = ~bus.cke;
      bus.din = 16'sd1234;
      tick();
    end
    check("rst.dout", bus.dout, 0);
    check("rst.cke_out", bus.cke_out, 0);
    check("rst.busy", bus.busy, 0);
    check("rst.ovf", bus.ovf, 0);
    bus.cke = 1'b0;
    bus.din = '0;
    rst = 1'b1;

    // Impulse response through phases 3 and 7
    set_taps(0);
    feed(32767);
    check("imp.nostart", bus.busy, 0);
    idle(11);
    feed(0); idle(11);
    feed(0); idle(11);
    feed_start(0, 4095, "imp0");
    idle(1);
    group(0, 8191, "imp1");
    group(0, 0, "imp2");
    group(0, 0, "imp3");

    // Unity DC gain
    do_reset();
    set_taps(1);
    group(8000, 4000, "dc0");
    group(8000, 8000, "dc1");
    group(8000, 8000, "dc2");

    // Saturation both ways, with floor on the mixed window
    do_reset();
    set_taps(2);
    group(32767, 32767, "satp0");
    group(32767, 32767, "satp1");
    group(-32768, -4, "mix");
    group(-32768, -32768, "satn");

    // Overrun: continuous cke; only starts at cke 3 and 15 are accepted
    do_reset();
    set_taps(0);
    p0 = pulses;
    bus.din = 16'sd100;
    bus.cke = 1'b1;
    idle(24);
    bus.cke = 1'b0;
    bus.din = '0;
    idle(20);
    check("ovr.pulses", pulses - p0, 2);
    check("ovr.ovf", bus.ovf, 1);
    idle(10);
    check("ovr.sticky", bus.ovf, 1);
    do_reset();
    check("ovr.clear", bus.ovf, 0);

    // Reset during MAC
    set_taps(0);
    p0 = pulses;
    feed(0); idle(11);
    feed(0); idle(11);
    feed(0); idle(11);
    feed(5000);
    idle(2);
    rst = 1'b0;
    tick();
    check("abort.busy", bus.busy, 0);
    rst = 1'b1;
    idle(15);
    check("abort.pulses", pulses - p0, 0);
    check("abort.dout", bus.dout, 0);
    feed(32767); idle(11);
    feed(0); idle(11);
    feed(0); idle(11);
    feed_start(0, 4095, "abort.next");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
